ysyx_23060111_ifu_prefetch: RTL and testbench
=============================================

// Module: ysyx_23060111_ifu_prefetch
// PURPOSE
//  Instruction fetch unit with an in-order prefetch buffer, the successor to the fixed single-instruction fetch path.
//  Issues sequential PC+4 requests to instruction memory over a valid/ready bus and buffers the returned words.
//  Delivers {inst, inst_pc} to the IDU over a valid/ready handshake.
//  A redirect from the EXU flushes the buffer, drops stale in-flight responses and restarts fetch at the new PC.
// PARAMETERS
//  XLEN      32            address/instruction width
//  DEPTH     4             prefetch FIFO entries; power of two, >=2; also the max outstanding requests
//  RESET_PC  32'h8000_0000 first fetch address after reset (4-byte aligned)
// PORTS
//  clk          in   1     clock, all state updates on rising edge
//  rst          in   1     synchronous reset, active-high
//  req_valid    out  1     memory fetch request valid
//  req_ready    in   1     memory accepts request
//  req_addr     out  XLEN  fetch address
//  rsp_valid    in   1     memory response valid (always accepted, no ready; responses in request order)
//  rsp_data     in   XLEN  fetched instruction word
//  inst_valid   out  1     buffered instruction available to IDU
//  inst_ready   in   1     IDU consumes instruction
//  inst         out  XLEN  instruction at FIFO head
//  inst_pc      out  XLEN  PC of instruction at FIFO head
//  redir_valid  in   1     redirect request (branch/jump/trap)
//  redir_pc     in   XLEN  redirect target
//  misalign_err out  1     one-cycle pulse: redirect target had pc[1:0]!=0
// BEHAVIOUR
//  State: fetch_pc, FIFO (DEPTH x {pc,inst}) with rd/wr pointers + count, inflight counter, drop counter ($clog2(DEPTH)+1 bits each).
//  Reset (rst=1 at edge): fetch_pc=RESET_PC, count=0, inflight=0, drop=0, misalign_err=0; req_valid, inst_valid are 0 while rst=1.
//  Request: req_valid = !rst && !redir_valid && (count+inflight+drop < DEPTH); req_addr = fetch_pc.
//   Handshake (req_valid&&req_ready): inflight+1, fetch_pc <= fetch_pc+4 mod 2^XLEN (0xFFFF_FFFC wraps to 0).
//   req_addr must stay stable while req_valid=1 and req_ready=0.
//  Response (rsp_valid): if drop>0 -> discard, drop-1; else push {pc of oldest in-flight req, rsp_data}, inflight-1.
//   Each FIFO entry's pc is derived from fetch_pc, count and inflight; no per-request PC queue is required.
//   rsp_valid with inflight=0 and drop=0 is a protocol error: ignore, no state change.
//  Output: inst_valid = (count!=0); inst/inst_pc = head entry; pop on inst_valid&&inst_ready.
//   Latency: response at edge N -> inst_valid=1 in cycle N+1 (registered FIFO, no bypass). Min req->inst = mem latency+1.
//  Simultaneous push+pop: count unchanged, both pointers advance. Credit rule guarantees push never sees a full FIFO.
//  Simultaneous handshake+response same cycle: inflight unchanged.
//  Redirect (redir_valid at edge), highest priority:
//   FIFO flushed (count=0, pointers reset), pop in same cycle ignored.
//   drop <= drop+inflight-(rsp_valid?1:0); inflight <= 0. Same-cycle response is always discarded.
//   fetch_pc <= {redir_pc[XLEN-1:2],2'b00}; misalign_err <= (redir_pc[1:0]!=0), else 0 next cycle.
//   First request at new PC may be issued in the cycle after redirect, even while drop>0 (credit counts drop).
//  Back-to-back redirects: each one re-applies the rules above; drop accumulates correctly.
//  rst mid-operation: all counters cleared; responses to pre-reset requests are the memory's responsibility (memory is reset too).
// TESTING
//  1 Reset, req_ready=1, 1-cycle memory, inst_ready=1 -> req_addr 0x8000_0000,_0004,_0008...; inst_pc follows in order, one inst/cycle.
//  2 inst_ready=0, DEPTH=4 -> exactly 4 requests issued, then req_valid=0; one pop -> exactly one new request.
//  3 2 requests in flight, redir_valid with redir_pc=0x8000_0100 -> both old responses dropped; first inst_pc seen=0x8000_0100.
//  4 redir_pc=0x8000_0102 -> misalign_err=1 for one cycle, next req_addr=0x8000_0100.
//  5 Redirect to 0xFFFF_FFF8 -> req_addr sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
//  6 Random req_ready/rsp latency/inst_ready/redirects vs reference model -> inst stream matches; inflight+drop+count<=DEPTH always.

Source files
------------

// File: rtl/ysyx_23060111_ifu_prefetch.sv
// Instruction fetch unit with an in-order prefetch FIFO. It issues sequential requests,
// buffers the returned words and flushes on redirect, dropping stale responses still in flight.
module ysyx_23060111_ifu_prefetch #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            rsp_valid,
  input  logic [XLEN-1:0] rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_pc,
  output logic            misalign_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW+1:0] DEPTH_W = DEPTH[CW+1:0];

  logic [XLEN-1:0] fifo_pc   [DEPTH];
  logic [XLEN-1:0] fifo_inst [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, inflight, drop;
  logic [XLEN-1:0] fetch_pc;

  logic [CW+1:0]   credit;
  logic            hs, rsp_drop, rsp_push, push_en, pop;
  logic [XLEN-1:0] push_pc;

  always_comb begin
    credit     = {2'b00, count} + {2'b00, inflight} + {2'b00, drop};
    req_valid  = !rst && !redir_valid && (credit < DEPTH_W);
    req_addr   = fetch_pc;
    hs         = req_valid && req_ready;
    rsp_drop   = rsp_valid && (drop != '0);
    rsp_push   = rsp_valid && (drop == '0) && (inflight != '0);
    push_en    = !rst && !redir_valid && rsp_push;
    inst_valid = !rst && (count != '0);
    pop        = inst_valid && inst_ready;
    inst       = fifo_inst[rd_ptr];
    inst_pc    = fifo_pc[rd_ptr];
    // Oldest live request sits inflight words behind the next fetch address.
    push_pc    = fetch_pc - (XLEN'(inflight) << 2);
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      fifo_pc[wr_ptr]   <= push_pc;
      fifo_inst[wr_ptr] <= rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc     <= RESET_PC;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      inflight     <= '0;
      drop         <= '0;
      misalign_err <= 1'b0;
    end else if (redir_valid) begin
      // Everything still outstanding becomes stale; a same-cycle response retires one of them.
      fetch_pc     <= {redir_pc[XLEN-1:2], 2'b00};
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      inflight     <= '0;
      drop         <= drop + inflight - CW'(rsp_drop || rsp_push);
      misalign_err <= (redir_pc[1:0] != 2'b00);
    end else begin
      misalign_err <= 1'b0;
      if (hs) fetch_pc <= fetch_pc + XLEN'(4);
      if (rsp_push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count    <= count + CW'(rsp_push) - CW'(pop);
      inflight <= inflight + CW'(hs) - CW'(rsp_push);
      drop     <= drop - CW'(rsp_drop);
    end
  end

endmodule

// File: tb/tb_ysyx_23060111_ifu_prefetch.sv
// Directed and randomised bench for the prefetching IFU, with an in-order memory model
// and an expected-PC scoreboard on the instruction stream.
module tb_ysyx_23060111_ifu_prefetch;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, rsp_valid, inst_valid, inst_ready;
  logic        redir_valid, misalign_err;
  logic [31:0] req_addr, rsp_data, inst, inst_pc, redir_pc;

  always #5 clk = ~clk;

  ysyx_23060111_ifu_prefetch #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .misalign_err(misalign_err)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] issued[$];
  int          tests = 0, fails = 0;
  int          cyc = 0, lat = 1, pops = 0;
  logic [31:0] exp_pc = RESET_PC;
  logic        exp_mis = 1'b0;
  logic        armed = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  logic        want_first = 1'b0;
  logic [31:0] first_pop_pc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: present memory response, sample outputs, update model, advance to next negedge.
  task automatic cycle();
    if (rst) begin
      mq.delete();
      rsp_valid = 1'b0;
      rsp_data  = '0;
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = '0;
    end
    #1;
    if (armed) check("misalign_err", misalign_err, exp_mis);
    if (rst) begin
      check("rst_req_valid", req_valid, 0);
      check("rst_inst_valid", inst_valid, 0);
    end else begin
      if (redir_valid) check("redir_req_valid", req_valid, 0);
      if (pend && !redir_valid) begin
        check("req_hold_valid", req_valid, 1);
        check("req_hold_addr", req_addr, pend_addr);
      end
      if (req_valid && req_ready) begin
        mq.push_back('{req_addr, cyc + lat});
        issued.push_back(req_addr);
      end
      check("outstanding_le_depth", mq.size() <= DEPTH, 1);
      if (inst_valid && inst_ready && !redir_valid) begin
        check("inst_pc", inst_pc, exp_pc);
        check("inst", inst, mem_word(exp_pc));
        if (want_first) begin
          first_pop_pc = inst_pc;
          want_first   = 1'b0;
        end
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
    end
    pend      = !rst && !redir_valid && req_valid && !req_ready;
    pend_addr = req_addr;
    exp_mis   = !rst && redir_valid && (redir_pc[1:0] != 2'b00);
    if (rst) exp_pc = RESET_PC;
    else if (redir_valid) exp_pc = {redir_pc[31:2], 2'b00};
    @(posedge clk);
    cyc++;
    armed = armed | rst;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; redir_valid = 1'b0; redir_pc = '0;
    req_ready = 1'b0; inst_ready = 1'b0; lat = 1;
    cycle();
    cycle();
    rst = 1'b0;
    issued.delete();
    pops = 0;
  endtask

  initial begin
    rst = 1'b1; req_ready = 1'b0; inst_ready = 1'b0;
    redir_valid = 1'b0; redir_pc = '0; rsp_valid = 1'b0; rsp_data = '0;

    // Sequential fetch, one instruction per cycle
    do_reset();
    #1;
    check("reset_req_addr", req_addr, 32'h8000_0000);
    check("reset_req_valid", req_valid, 1);
    check("reset_inst_valid", inst_valid, 0);
    check("reset_misalign", misalign_err, 0);
    req_ready = 1'b1; inst_ready = 1'b1; lat = 1;
    repeat (10) cycle();
    check("seq_issue_count", issued.size(), 10);
    for (int i = 0; i < 10; i++) check("seq_addr", issued[i], 32'h8000_0000 + 32'(4 * i));
    check("seq_pop_count", pops, 8);

    // Credit limit with a stalled consumer
    do_reset();
    req_ready = 1'b1; inst_ready = 1'b0; lat = 1;
    repeat (8) cycle();
    check("full_issue_count", issued.size(), 4);
    check("full_req_valid", req_valid, 0);
    check("full_inst_valid", inst_valid, 1);
    check("full_head_pc", inst_pc, 32'h8000_0000);
    inst_ready = 1'b1;
    cycle();
    inst_ready = 1'b0;
    repeat (4) cycle();
    check("refill_issue_count", issued.size(), 5);
    check("refill_addr", issued[4], 32'h8000_0010);
    check("refill_req_valid", req_valid, 0);

    // Redirect with two requests in flight
    do_reset();
    req_ready = 1'b1; inst_ready = 1'b0; lat = 3;
    cycle();
    cycle();
    req_ready = 1'b0; redir_valid = 1'b1; redir_pc = 32'h8000_0100;
    cycle();
    redir_valid = 1'b0;
    issued.delete();
    want_first = 1'b1; first_pop_pc = '0;
    req_ready = 1'b1; inst_ready = 1'b1; lat = 1;
    repeat (10) cycle();
    check("redir_first_req", issued[0], 32'h8000_0100);
    check("redir_first_inst_pc", first_pop_pc, 32'h8000_0100);

    // Misaligned redirect target
    redir_valid = 1'b1; redir_pc = 32'h8000_0102;
    cycle();
    redir_valid = 1'b0;
    #1;
    check("misalign_pulse", misalign_err, 1);
    check("misalign_req_valid", req_valid, 1);
    check("misalign_req_addr", req_addr, 32'h8000_0100);
    cycle();
    check("misalign_clear", misalign_err, 0);

    // Address wrap at the top of the space
    redir_valid = 1'b1; redir_pc = 32'hFFFF_FFF8;
    cycle();
    redir_valid = 1'b0;
    issued.delete();
    repeat (8) cycle();
    check("wrap_issue_count", issued.size() >= 3, 1);
    check("wrap_addr0", issued[0], 32'hFFFF_FFF8);
    check("wrap_addr1", issued[1], 32'hFFFF_FFFC);
    check("wrap_addr2", issued[2], 32'h0000_0000);

    // Randomised traffic with redirects and one mid-run reset
    pops = 0;
    for (int i = 0; i < 400; i++) begin
      rst         = (i == 200);
      req_ready   = ($urandom_range(0, 3) != 0);
      inst_ready  = $urandom_range(0, 1) == 1;
      lat         = $urandom_range(1, 4);
      redir_valid = ($urandom_range(0, 19) == 0);
      redir_pc    = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
      cycle();
    end
    rst = 1'b0; redir_valid = 1'b0; req_ready = 1'b1; inst_ready = 1'b1;
    repeat (20) cycle();
    check("random_progress", pops > 50, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
